// File: rtl/pes_elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package pes_elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width of a down-counter that must hold values up to max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pes_elevator_dir_sel.sv
// Reports whether requests lie ahead of or behind the car in its current direction.
module pes_elevator_dir_sel
  import pes_elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 8
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [NUM_FLOORS-1:0] cur_floor,
  input  logic                  direction,
  output logic                  ahead,
  output logic                  behind
);

  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] above_mask;

  // One-hot minus one sets every bit strictly below the car.
  assign below_mask = cur_floor - NUM_FLOORS'(1);
  assign above_mask = ~(below_mask | cur_floor);

  always_comb begin
    ahead  = 1'b0;
    behind = 1'b0;
    if (direction == DIR_UP) begin
      ahead  = |(pending & above_mask);
      behind = |(pending & below_mask);
    end else begin
      ahead  = |(pending & below_mask);
      behind = |(pending & above_mask);
    end
  end

endmodule

// File: rtl/pes_elevator_scan.sv
// Multi-request elevator controller serving a request bitmap in SCAN order.
module pes_elevator_scan
  import pes_elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned FLOOR_TICKS = 4,
  parameter int unsigned DOOR_TICKS  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] request_floor,
  input  logic                  over_time,
  input  logic                  over_weight,
  output logic [NUM_FLOORS-1:0] out_current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  complete,
  output logic                  door_alert,
  output logic                  weight_alert,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned CntW = cnt_width(FLOOR_TICKS, DOOR_TICKS);
  localparam logic [CntW-1:0] FloorReload = CntW'(FLOOR_TICKS - 1);
  localparam logic [CntW-1:0] DoorReload  = CntW'(DOOR_TICKS - 1);

  state_e                state;
  logic [CntW-1:0]       cnt;
  logic [NUM_FLOORS-1:0] all_req;
  logic [NUM_FLOORS-1:0] next_floor;
  logic                  here_req;
  logic                  ahead;
  logic                  behind;

  // Requests arriving this cycle take part in this cycle's decisions.
  assign all_req    = pending | request_floor;
  assign next_floor = (direction == DIR_UP) ? (out_current_floor << 1) : (out_current_floor >> 1);
  assign here_req   = |(request_floor & out_current_floor);

  pes_elevator_dir_sel #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_dir_sel (
    .pending   (all_req),
    .cur_floor (out_current_floor),
    .direction (direction),
    .ahead     (ahead),
    .behind    (behind)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      out_current_floor <= NUM_FLOORS'(1);
      direction         <= DIR_UP;
      pending           <= '0;
      complete          <= 1'b0;
    end else begin
      complete <= 1'b0;
      unique case (state)
        IDLE: begin
          pending <= all_req & ~out_current_floor;
          if (here_req) begin
            state    <= DOOR;
            cnt      <= DoorReload;
            complete <= 1'b1;
          end else if ((ahead || behind) && !over_weight) begin
            if (!ahead) direction <= ~direction;
            state <= MOVE;
            cnt   <= FloorReload;
          end
        end
        MOVE: begin
          pending <= all_req;
          if (cnt == '0) begin
            out_current_floor <= next_floor;
            if (|(all_req & next_floor)) begin
              pending  <= all_req & ~next_floor;
              complete <= 1'b1;
              state    <= DOOR;
              cnt      <= DoorReload;
            end else begin
              cnt <= FloorReload;
            end
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        DOOR: begin
          pending <= all_req & ~out_current_floor;
          if (here_req) begin
            cnt      <= DoorReload;
            complete <= 1'b1;
          end else if (over_time || over_weight) begin
            cnt <= DoorReload;
          end else if (cnt == '0) begin
            if (ahead) begin
              state <= MOVE;
              cnt   <= FloorReload;
            end else if (behind) begin
              direction <= ~direction;
              state     <= MOVE;
              cnt       <= FloorReload;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign moving       = (state == MOVE);
  assign door_open    = (state == DOOR);
  assign door_alert   = over_time && (state == DOOR);
  assign weight_alert = over_weight && ((state == DOOR) || (state == IDLE));

endmodule
